// File: rtl/booth_mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// booth_mult_seq_pkg
// Shared definitions for the sequential radix-4 Booth multiplier:
//   - state_t       : FSM state encodings (IDLE, RUN, DONE)
//   - DIG_*         : Booth digit encodings produced by the recoder
//   - booth_recode  : maps the 3-bit window {b[i+1], b[i], b[i-1]} to a digit
// No ports (package).
// -----------------------------------------------------------------------------
package booth_mult_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Booth digit encodings: 0, +M, +2M, -M, -2M.
   localparam logic [2:0] DIG_ZERO = 3'd0;
   localparam logic [2:0] DIG_P1   = 3'd1;
   localparam logic [2:0] DIG_P2   = 3'd2;
   localparam logic [2:0] DIG_M1   = 3'd3;
   localparam logic [2:0] DIG_M2   = 3'd4;

   // Radix-4 recoding of {lo[1], lo[0], helper}.
   function automatic logic [2:0] booth_recode(input logic [2:0] win);
      logic [2:0] dig;
      unique case (win)
         3'b001, 3'b010: dig = DIG_P1;
         3'b011:         dig = DIG_P2;
         3'b100:         dig = DIG_M2;
         3'b101, 3'b110: dig = DIG_M1;
         default:        dig = DIG_ZERO;  // 000 and 111
      endcase
      return dig;
   endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// -----------------------------------------------------------------------------
// booth_mult_seq_if
// Request/result bundle of the sequential Booth multiplier.
//   start          : request, sampled only in IDLE or DONE
//   is_signed      : 1 = two's-complement operands, 0 = unsigned
//   data_operandA  : multiplicand (WIDTH)
//   data_operandB  : multiplier   (WIDTH)
//   busy           : high while the multiplier is iterating
//   data_resultRDY : one-cycle pulse when the product becomes valid
//   product        : full 2*WIDTH-bit product
//   overflow       : product does not fit in WIDTH bits
// Modports: master drives the request, slave is the multiplier.
// -----------------------------------------------------------------------------
interface booth_mult_seq_if #(
   parameter int WIDTH = 32
);

   logic                 start;
   logic                 is_signed;
   logic [WIDTH-1:0]     data_operandA;
   logic [WIDTH-1:0]     data_operandB;
   logic                 busy;
   logic                 data_resultRDY;
   logic [2*WIDTH-1:0]   product;
   logic                 overflow;

   modport master (
      output start, is_signed, data_operandA, data_operandB,
      input  busy, data_resultRDY, product, overflow
   );

   modport slave (
      input  start, is_signed, data_operandA, data_operandB,
      output busy, data_resultRDY, product, overflow
   );

endinterface

// File: rtl/booth_r4_step.sv
// -----------------------------------------------------------------------------
// booth_r4_step
// One combinational radix-4 Booth iteration: recode, add 0/+-M/+-2M to the
// upper accumulator half, then arithmetic-shift the pair right by two.
// Ports:
//   i_hi       : upper accumulator half (WIDTH+2, two's complement)
//   i_lo       : two lowest bits of the lower accumulator half
//   i_helper   : Booth helper bit (bit shifted out by the previous step)
//   i_m        : multiplicand, extended to WIDTH+2
//   o_hi       : next upper half after add and shift
//   o_lo_in    : two bits shifted from the sum into the top of the lower half
//   o_helper   : next helper bit (old lo[1])
// -----------------------------------------------------------------------------
module booth_r4_step
   import booth_mult_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH+1:0] i_hi,
   input  logic [1:0]       i_lo,
   input  logic             i_helper,
   input  logic [WIDTH+1:0] i_m,
   output logic [WIDTH+1:0] o_hi,
   output logic [1:0]       o_lo_in,
   output logic             o_helper
);

   localparam int AW = WIDTH + 2;

   logic [2:0]    w_digit;
   logic [AW-1:0] w_addend;
   logic [AW-1:0] w_sum;

   // NOTE: every signal assigned in always_comb gets a value on every path
   // (default arm below), otherwise synthesis infers a latch.
   always_comb begin
      w_digit = booth_recode({i_lo, i_helper});
      unique case (w_digit)
         DIG_P1:  w_addend = i_m;
         DIG_P2:  w_addend = {i_m[AW-2:0], 1'b0};
         DIG_M1:  w_addend = -i_m;
         DIG_M2:  w_addend = -{i_m[AW-2:0], 1'b0};
         default: w_addend = '0;
      endcase

      // Carry out of the WIDTH+2 adder is discarded; the two guard bits keep
      // +-2M of any operand representable.
      w_sum    = i_hi + w_addend;
      o_hi     = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
      o_lo_in  = w_sum[1:0];
      o_helper = i_lo[1];
   end

endmodule

// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
// Sequential radix-4 Booth multiplier. Latches two WIDTH-bit operands on an
// accepted start, retires two multiplier bits per clock and registers a
// 2*WIDTH-bit product plus an overflow flag (result does not fit in WIDTH).
// Latency from accepting edge to DONE: WIDTH/2 (signed), WIDTH/2+1 (unsigned).
// Ports:
//   i_clk  : rising-edge clock
//   i_rst  : asynchronous active-high reset, clears all state
//   bus    : booth_mult_seq_if.slave (request operands, busy/ready/result)
// -----------------------------------------------------------------------------
module booth_mult_seq
   import booth_mult_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   booth_mult_seq_if.slave        bus
);

   localparam int AW    = WIDTH + 2;              // accumulator half width
   localparam int CNT_W = $clog2(WIDTH / 2 + 2);  // holds 0..WIDTH/2+1

   // Counter value at which the final iteration is performed (N-1).
   localparam logic [CNT_W-1:0] LAST_S = CNT_W'(WIDTH / 2 - 1);
   localparam logic [CNT_W-1:0] LAST_U = CNT_W'(WIDTH / 2);

   state_t               r_state;
   logic [AW-1:0]        r_m;
   logic [AW-1:0]        r_hi;
   logic [AW-1:0]        r_lo;
   logic                 r_helper;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     r_last;
   logic                 r_signed;
   logic                 r_busy;
   logic                 r_rdy;
   logic [2*WIDTH-1:0]   r_product;
   logic                 r_ovf;

   logic [AW-1:0]        w_next_hi;
   logic [1:0]           w_lo_in;
   logic                 w_next_helper;
   logic [AW-1:0]        w_next_lo;
   logic [2*WIDTH-1:0]   w_product;
   logic                 w_ovf;
   logic [AW-1:0]        w_ext_a;
   logic [AW-1:0]        w_ext_b;

   booth_r4_step #(.WIDTH(WIDTH)) u_step (
      .i_hi     (r_hi),
      .i_lo     (r_lo[1:0]),
      .i_helper (r_helper),
      .i_m      (r_m),
      .o_hi     (w_next_hi),
      .o_lo_in  (w_lo_in),
      .o_helper (w_next_helper)
   );

   always_comb begin
      w_ext_a = bus.is_signed ? {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA}
                              : {2'b00, bus.data_operandA};
      w_ext_b = bus.is_signed ? {{2{bus.data_operandB[WIDTH-1]}}, bus.data_operandB}
                              : {2'b00, bus.data_operandB};

      w_next_lo = {w_lo_in, r_lo[AW-1:2]};

      // The lower half is always WIDTH+2 bits wide. A signed operation runs one
      // iteration fewer, so its two unused extension bits end up at the bottom
      // of lo and the product sits two bits higher in {hi, lo}.
      if (r_signed)
         w_product = {w_next_hi[WIDTH-1:0], w_next_lo[AW-1:2]};
      else
         w_product = {w_next_hi[WIDTH-3:0], w_next_lo};

      if (r_signed)
         w_ovf = !((&w_product[2*WIDTH-1:WIDTH-1]) || !(|w_product[2*WIDTH-1:WIDTH-1]));
      else
         w_ovf = |w_product[2*WIDTH-1:WIDTH];
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_m       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_helper  <= 1'b0;
         r_cnt     <= '0;
         r_last    <= '0;
         r_signed  <= 1'b0;
         r_busy    <= 1'b0;
         r_rdy     <= 1'b0;
         r_product <= '0;
         r_ovf     <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               r_rdy <= 1'b0;
               if (bus.start) begin
                  r_m      <= w_ext_a;
                  r_hi     <= '0;
                  r_lo     <= w_ext_b;
                  r_helper <= 1'b0;
                  r_cnt    <= '0;
                  r_last   <= bus.is_signed ? LAST_S : LAST_U;
                  r_signed <= bus.is_signed;
                  r_busy   <= 1'b1;
                  r_state  <= S_RUN;
               end else begin
                  r_state  <= S_IDLE;
               end
            end

            S_RUN: begin
               // start is ignored here; operands stay as latched.
               r_hi     <= w_next_hi;
               r_lo     <= w_next_lo;
               r_helper <= w_next_helper;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (r_cnt == r_last) begin
                  r_product <= w_product;
                  r_ovf     <= w_ovf;
                  r_busy    <= 1'b0;
                  r_rdy     <= 1'b1;
                  r_state   <= S_DONE;
               end
            end

            default: begin
               r_busy  <= 1'b0;
               r_rdy   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy           = r_busy;
   assign bus.data_resultRDY = r_rdy;
   assign bus.product        = r_product;
   assign bus.overflow       = r_ovf;

endmodule
